// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle main control FSM sequencing one instruction over 3-5 cycles
//
// Ports:
//   clk, rst           rising-edge clock; asynchronous active-low reset (rst low = reset)
//   en                 step enable; low freezes the FSM and suppresses all write strobes
//   opcode[5:0]        instr[31:26] from the instruction register
//   mem_ready          unified memory finished the current access this cycle
//   pc_write           unconditional PC load
//   pc_write_cond      PC load qualified by ALU zero (branch)
//   i_or_d             memory address select: 0 = PC, 1 = ALU out
//   mem_read/mem_write memory strobes
//   ir_write           instruction register load
//   reg_dst            register-file destination select (1 = rd, 0 = rt)
//   mem_to_reg         register-file write data select (1 = memory data)
//   reg_write          register-file write enable
//   alu_src_a          ALU operand A select (0 = PC, 1 = rs)
//   alu_src_b[1:0]     ALU operand B select (00 rt, 01 +4, 10 imm, 11 imm<<2)
//   alu_op[1:0]        ALU operation class (00 add, 01 sub, 10 funct)
//   pc_source[1:0]     next-PC select (00 ALU, 01 ALU out, 10 jump target)
//   instr_done         one-cycle pulse on the last cycle of each instruction
//   illegal_op         one-cycle pulse when DECODE sees an unsupported opcode
//   state[3:0]         current state code, for debug
//   retired[31:0]      wrapping count of completed instructions

module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        instr_done,
    output logic        illegal_op,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_IMMSH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] retired_q;

    // Strobes before the enable gate; selects need no gating.
    logic raw_pc_write;
    logic raw_pc_write_cond;
    logic raw_ir_write;
    logic raw_reg_write;
    logic raw_mem_write;
    logic raw_instr_done;
    logic raw_illegal_op;

    // State register: en low freezes the sequence in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // instr_done is already en-gated, so a frozen cycle never retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= 32'd0;
        end else if (instr_done) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    always_comb begin
        state_d           = state_q;
        raw_pc_write      = 1'b0;
        raw_pc_write_cond = 1'b0;
        raw_ir_write      = 1'b0;
        raw_reg_write     = 1'b0;
        raw_mem_write     = 1'b0;
        raw_instr_done    = 1'b0;
        raw_illegal_op    = 1'b0;
        i_or_d            = 1'b0;
        mem_read          = 1'b0;
        reg_dst           = 1'b0;
        mem_to_reg        = 1'b0;
        alu_src_a         = 1'b0;
        alu_src_b         = SRC_B_REG;
        alu_op            = ALU_ADD;
        pc_source         = PC_SRC_ALU;

        case (state_q)
            S_FETCH: begin
                // Instruction read and PC+4 share this cycle; IR and PC
                // capture only once memory has delivered the word.
                mem_read     = 1'b1;
                alu_src_b    = SRC_B_FOUR;
                raw_ir_write = mem_ready;
                raw_pc_write = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                // Speculative branch target PC + (imm << 2).
                alu_src_b = SRC_B_IMMSH;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        // Unsupported opcode retires as a two-cycle no-op.
                        state_d        = S_FETCH;
                        raw_illegal_op = 1'b1;
                        raw_instr_done = 1'b1;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                // IR is stable, so the opcode is simply looked at again here.
                if (opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end

            S_MEM_WB: begin
                mem_to_reg     = 1'b1;
                raw_reg_write  = 1'b1;
                raw_instr_done = 1'b1;
                state_d        = S_FETCH;
            end

            S_MEM_WRITE: begin
                // Write strobe stays up across wait states; the store
                // completes in the cycle memory acknowledges it.
                i_or_d         = 1'b1;
                raw_mem_write  = 1'b1;
                raw_instr_done = mem_ready;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end

            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_REG;
                alu_op    = ALU_FUNCT;
                state_d   = S_R_WB;
            end

            S_R_WB: begin
                reg_dst        = 1'b1;
                raw_reg_write  = 1'b1;
                raw_instr_done = 1'b1;
                state_d        = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a         = 1'b1;
                alu_src_b         = SRC_B_REG;
                alu_op            = ALU_SUB;
                pc_source         = PC_SRC_ALUOUT;
                raw_pc_write_cond = 1'b1;
                raw_instr_done    = 1'b1;
                state_d           = S_FETCH;
            end

            S_JUMP: begin
                pc_source      = PC_SRC_JUMP;
                raw_pc_write   = 1'b1;
                raw_instr_done = 1'b1;
                state_d        = S_FETCH;
            end

            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = S_ADDI_WB;
            end

            S_ADDI_WB: begin
                raw_reg_write  = 1'b1;
                raw_instr_done = 1'b1;
                state_d        = S_FETCH;
            end

            // Unused codes 12-15 recover to FETCH with everything idle.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign pc_write      = raw_pc_write      & en;
    assign pc_write_cond = raw_pc_write_cond & en;
    assign ir_write      = raw_ir_write      & en;
    assign reg_write     = raw_reg_write     & en;
    assign mem_write     = raw_mem_write     & en;
    assign instr_done    = raw_instr_done    & en;
    assign illegal_op    = raw_illegal_op    & en;

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard testbench for multicycle_control

module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic        en;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_source;
    logic        instr_done;
    logic        illegal_op;
    logic [3:0]  state;
    logic [31:0] retired;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .state         (state),
        .retired       (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation order, bit 17 down to 0:
    // pc_write pc_write_cond i_or_d mem_read mem_write ir_write reg_dst
    // mem_to_reg reg_write alu_src_a alu_src_b[2] alu_op[2] pc_source[2]
    // instr_done illegal_op
    logic [17:0] got_outs;
    assign got_outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_source, instr_done, illegal_op};

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [17:0] outs;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_ret     = 32'd0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // Expected output vector for a state, written out from the control table.
    function automatic logic [17:0] exp_outs(input logic [3:0] st, input logic e,
                                             input logic mr, input logic [5:0] op);
        logic pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, asa, done, ill;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, asa, done, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            4'd0:  begin mrd = 1; asb = 2'b01; irw = mr & e; pw = mr & e; end
            4'd1:  begin asb = 2'b11; if (!is_legal(op)) begin ill = e; done = e; end end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iod = 1; end
            4'd4:  begin m2r = 1; rw = e; done = e; end
            4'd5:  begin iod = 1; mwr = e; done = mr & e; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rd = 1; rw = e; done = e; end
            4'd8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pwc = e; done = e; end
            4'd9:  begin psrc = 2'b10; pw = e; done = e; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: begin rw = e; done = e; end
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop, psrc, done, ill};
    endfunction

    // Drive one cycle and log what the DUT must show during it.
    task automatic step(input string tag, input logic [3:0] st, input logic e,
                        input logic mr, input logic [5:0] op);
        exp_t x;
        en        = e;
        mem_ready = mr;
        opcode    = op;
        x.tag  = tag;
        x.st   = st;
        x.outs = exp_outs(st, e, mr, op);
        x.ret  = exp_ret;
        sb.push_back(x);
        if (x.outs[1]) exp_ret = exp_ret + 32'd1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check_eq({x.tag, ".state"}, 64'(state), 64'(x.st));
            check_eq({x.tag, ".outs"}, 64'(got_outs), 64'(x.outs));
            check_eq({x.tag, ".retired"}, 64'(retired), 64'(x.ret));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; en = 1'b0; mem_ready = 1'b0; opcode = OP_R;
        #3;
        check_eq("reset.state", 64'(state), 64'd0);
        check_eq("reset.retired", 64'(retired), 64'd0);
        check_eq("reset.outs", 64'(got_outs), 64'(exp_outs(4'd0, 1'b0, 1'b0, OP_R)));
        @(posedge clk); #1;
        rst = 1'b1;

        // lw, zero wait states: 0,1,2,3,4
        step("lw0", 4'd0, 1, 1, OP_LW);
        step("lw1", 4'd1, 1, 1, OP_LW);
        step("lw2", 4'd2, 1, 1, OP_LW);
        step("lw3", 4'd3, 1, 1, OP_LW);
        step("lw4", 4'd4, 1, 1, OP_LW);
        check_eq("lw.retired", 64'(retired), 64'd1);

        // sw with three wait states in MEM_WRITE: 7 cycles
        step("sw0", 4'd0, 1, 1, OP_SW);
        step("sw1", 4'd1, 1, 1, OP_SW);
        step("sw2", 4'd2, 1, 1, OP_SW);
        for (int i = 0; i < 3; i++) step("sw_wait", 4'd5, 1, 0, OP_SW);
        step("sw_ack", 4'd5, 1, 1, OP_SW);
        check_eq("sw.retired", 64'(retired), 64'd2);

        // beq then j back to back
        step("beq0", 4'd0, 1, 1, OP_BEQ);
        step("beq1", 4'd1, 1, 1, OP_BEQ);
        step("beq8", 4'd8, 1, 1, OP_BEQ);
        step("j0",   4'd0, 1, 1, OP_J);
        step("j1",   4'd1, 1, 1, OP_J);
        step("j9",   4'd9, 1, 1, OP_J);
        check_eq("beqj.retired", 64'(retired), 64'd4);

        // illegal opcode: FETCH, DECODE, FETCH
        step("ill0", 4'd0, 1, 1, OP_BAD);
        step("ill1", 4'd1, 1, 1, OP_BAD);
        check_eq("ill.retired", 64'(retired), 64'd5);

        // R-type with en low for 5 cycles in EXECUTE
        step("r0", 4'd0, 1, 1, OP_R);
        step("r1", 4'd1, 1, 1, OP_R);
        for (int i = 0; i < 5; i++) step("r6_frozen", 4'd6, 0, 1, OP_R);
        step("r6", 4'd6, 1, 1, OP_R);
        step("r7", 4'd7, 1, 1, OP_R);
        check_eq("r.retired", 64'(retired), 64'd6);

        // addi
        step("addi0",  4'd0,  1, 1, OP_ADDI);
        step("addi1",  4'd1,  1, 1, OP_ADDI);
        step("addi10", 4'd10, 1, 1, OP_ADDI);
        step("addi11", 4'd11, 1, 1, OP_ADDI);
        check_eq("addi.retired", 64'(retired), 64'd7);

        // FETCH wait, en-wins-over-ready, MEM_READ wait
        step("fw_wait",  4'd0, 1, 0, OP_LW);
        step("fw_en0",   4'd0, 0, 1, OP_LW);
        step("fw0",      4'd0, 1, 1, OP_LW);
        step("fw1",      4'd1, 1, 1, OP_LW);
        step("fw2",      4'd2, 1, 1, OP_LW);
        step("fw3_wait", 4'd3, 1, 0, OP_LW);
        step("fw3",      4'd3, 1, 1, OP_LW);
        step("fw4",      4'd4, 1, 1, OP_LW);
        check_eq("fw.retired", 64'(retired), 64'd8);

        // illegal decode frozen by en: no pulse until en returns
        step("ie0",     4'd0, 1, 1, OP_BAD);
        step("ie1_en0", 4'd1, 0, 1, OP_BAD);
        step("ie1",     4'd1, 1, 1, OP_BAD);
        check_eq("ie.retired", 64'(retired), 64'd9);

        // asynchronous reset mid-cycle while waiting in MEM_READ
        step("ar0", 4'd0, 1, 1, OP_LW);
        step("ar1", 4'd1, 1, 1, OP_LW);
        step("ar2", 4'd2, 1, 1, OP_LW);
        mem_ready = 1'b0;
        #2;
        check_eq("ar.pre_state", 64'(state), 64'd3);
        rst = 1'b0;
        #1;
        check_eq("ar.state", 64'(state), 64'd0);
        check_eq("ar.retired", 64'(retired), 64'd0);
        check_eq("ar.outs", 64'(got_outs), 64'(exp_outs(4'd0, 1'b1, 1'b0, OP_LW)));
        exp_ret = 32'd0;
        @(posedge clk); #1;
        check_eq("ar.held", 64'(state), 64'd0);
        rst = 1'b1;
        step("pr0", 4'd0, 1, 1, OP_LW);
        step("pr1", 4'd1, 1, 1, OP_LW);
        step("pr2", 4'd2, 1, 1, OP_LW);
        step("pr3", 4'd3, 1, 1, OP_LW);
        step("pr4", 4'd4, 1, 1, OP_LW);
        check_eq("pr.retired", 64'(retired), 64'd1);

        if (sb.size() != 0) begin
            check_eq("sb.drained", 64'(sb.size()), 64'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
